// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared widths, state encodings and control levels for the divide sequencer
package div_seq_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_ANNUL            = 1'b1;
    localparam logic DIV_NOT_ANNUL        = 1'b0;

endpackage

// File: rtl/div_seq_step.sv
// rtl/div_seq_step.sv - one restoring-division iteration: shift, trial subtract, pick quotient bit
module div_seq_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_partial_rem,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_partial_rem,
    output logic [DATA_W-1:0] o_dividend
);

    logic [DATA_W:0] w_shift;
    logic [DATA_W:0] w_diff;
    logic            w_qbit;

    // partial_rem < divisor always holds, so DATA_W+1 bits suffice and the MSB is the borrow
    assign w_shift = {i_partial_rem, i_dividend[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign w_qbit  = ~w_diff[DATA_W];

    assign o_partial_rem = w_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
    assign o_dividend    = {i_dividend[DATA_W-2:0], w_qbit};

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle signed/unsigned divide sequencer returning {remainder, quotient}
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DATA_W);

    div_state_e          r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_rem, w_rem_nxt;
    logic [DATA_W-1:0]   r_dvd, w_dvd_nxt;
    logic [DATA_W-1:0]   r_dvs, w_dvs_nxt;
    logic                r_neg_q, w_neg_q_nxt;
    logic                r_neg_r, w_neg_r_nxt;
    logic [2*DATA_W-1:0] r_result, w_result_nxt;
    logic                r_ready, w_ready_nxt;

    logic [DATA_W-1:0]   w_step_rem;
    logic [DATA_W-1:0]   w_step_dvd;
    logic [DATA_W-1:0]   w_abs1;
    logic [DATA_W-1:0]   w_abs2;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;

    div_seq_step #(.DATA_W(DATA_W)) u_step (
        .i_partial_rem (r_rem),
        .i_dividend    (r_dvd),
        .i_divisor     (r_dvs),
        .o_partial_rem (w_step_rem),
        .o_dividend    (w_step_dvd)
    );

    // Most negative value negates to itself and is then divided as its unsigned magnitude
    assign w_abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign w_abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    assign w_quo_fix = r_neg_q ? -r_dvd : r_dvd;
    assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rem_nxt    = r_rem;
        w_dvd_nxt    = r_dvd;
        w_dvs_nxt    = r_dvs;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_result_nxt = r_result;
        w_ready_nxt  = r_ready;
        case (r_state)
            DIV_FREE: begin
                if (start_i == DIV_START && annul_i == DIV_NOT_ANNUL) begin
                    w_cnt_nxt   = '0;
                    w_rem_nxt   = '0;
                    w_dvd_nxt   = w_abs1;
                    w_dvs_nxt   = w_abs2;
                    w_neg_q_nxt = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    w_neg_r_nxt = signed_div_i & opdata1_i[DATA_W-1];
                    w_state_nxt = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                w_result_nxt = '0;
                w_ready_nxt  = DIV_RESULT_READY;
                w_state_nxt  = DIV_END;
            end
            DIV_ON: begin
                if (annul_i == DIV_ANNUL) begin
                    w_cnt_nxt    = '0;
                    w_result_nxt = '0;
                    w_ready_nxt  = DIV_RESULT_NOT_READY;
                    w_state_nxt  = DIV_FREE;
                end else if (r_cnt != LP_CNT_LAST) begin
                    w_rem_nxt = w_step_rem;
                    w_dvd_nxt = w_step_dvd;
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_result_nxt = {w_rem_fix, w_quo_fix};
                    w_ready_nxt  = DIV_RESULT_READY;
                    w_state_nxt  = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    w_result_nxt = '0;
                    w_ready_nxt  = DIV_RESULT_NOT_READY;
                    w_state_nxt  = DIV_FREE;
                end
            end
            default: w_state_nxt = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= DIV_FREE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_ready  <= DIV_RESULT_NOT_READY;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rem    <= w_rem_nxt;
            r_dvd    <= w_dvd_nxt;
            r_dvs    <= w_dvs_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_result <= w_result_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign result_o   = r_result;
    assign ready_o    = r_ready;
    assign stallreq_o = start_i & ~r_ready & ~annul_i;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq against an arithmetic reference model
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        x = sg ? longint'($signed(a)) : longint'({32'd0, a});
        y = sg ? longint'($signed(b)) : longint'({32'd0, b});
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    logic prev_rdy = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            prev_rdy = 1'b0;
        end else begin
            if (ready_o && !prev_rdy) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready: got ready=1 expected no pending divide (t=%0t)", $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", result_o, mon_e.res);
                    chk("latency_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end
            prev_rdy = ready_o;
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic sg);
        exp_t e;
        e.res = model(a, b, sg);
        e.due = cyc + 1 + ((b == 32'd0) ? 1 : 33);
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg);
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sg;
        start_i      = 1'b1;
        push(a, b, sg);
    endtask

    task automatic wait_done(input int exp_stall, input int hold);
        int stalls;
        int n;
        logic [63:0] r;
        stalls = 0;
        n = 0;
        #1;
        while (!ready_o && n < 300) begin
            if (stallreq_o) stalls++;
            n++;
            @(negedge clk);
            if (n == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            #1;
        end
        if (!ready_o) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles expected ready", n);
        end
        chk("stall_cycles", 64'(stalls), 64'(exp_stall));
        chk("stall_off_when_ready", 64'(stallreq_o), 64'd0);
        r = result_o;
        repeat (hold) begin
            @(negedge clk);
            #1;
            chk("hold_ready", 64'(ready_o), 64'd1);
            chk("hold_result", result_o, r);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        #1;
        chk("drop_ready", 64'(ready_o), 64'd0);
        chk("drop_result", result_o, 64'd0);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg, input int hold);
        issue(a, b, sg);
        wait_done((b == 32'd0) ? 2 : 34, hold);
    endtask

    initial begin
        int n;
        logic [31:0] a, b;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        chk("reset_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div(32'd100, 32'd7, 1'b0, 2);
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, 1);
        run_div(32'd7, 32'hFFFFFFFE, 1'b1, 0);
        run_div(32'h1234, 32'd0, 1'b0, 1);
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
        run_div(32'hFFFFFFFF, 32'h10, 1'b0, 0);

        // start and annul together in idle must not accept
        @(negedge clk);
        opdata1_i = 32'd50; opdata2_i = 32'd5; signed_div_i = 1'b0;
        start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("start_annul_stall", 64'(stallreq_o), 64'd0);
        chk("start_annul_ready", 64'(ready_o), 64'd0);
        start_i = 1'b0; annul_i = 1'b0;

        // annul in the 10th ON cycle
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0;
        start_i = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        #1;
        chk("annul_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("annul_no_ready", 64'(ready_o), 64'd0);
        run_div(32'd9, 32'd3, 1'b0, 1);

        // async reset mid-ON, then re-accept with start held
        @(negedge clk);
        opdata1_i = 32'd12345; opdata2_i = 32'd17; signed_div_i = 1'b0;
        start_i = 1'b1;
        repeat (15) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_on_ready", 64'(ready_o), 64'd0);
        chk("rst_on_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        push(32'd12345, 32'd17, 1'b0);
        wait_done(34, 4);

        // async reset while a result is held
        issue(32'hFFFFFF00, 32'd7, 1'b1);
        n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("rst_end_ready", 64'(ready_o), 64'd0);
        chk("rst_end_result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = $urandom;
                default: b = -32'($urandom_range(1, 9));
            endcase
            run_div(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
